// File: rtl/avst_pkg.sv
// Shared types and constants for the Avalon-ST sink FIFO slice.
package avst_pkg;

    localparam int AVST_DATA_W = 16;
    localparam int PKT_CNT_W   = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/avalon_st_sink_fifo_if.sv
// Avalon-ST beat bundle: payload, frame markers and valid/ready handshake.
interface avalon_st_sink_fifo_if
    import avst_pkg::*;
#(
    parameter int DATA_W = AVST_DATA_W
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;

    modport master (output valid, data, sop, eop, input ready);
    modport slave  (input valid, data, sop, eop, output ready);

endinterface

// File: rtl/avst_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered level/full/empty flags.
module avst_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic [AW:0]      level_nxt_s;
    logic             full_r;
    logic             empty_r;

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push, pop})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointer, level and flag registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= LVL_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LVL_FULL);
            empty_r <= (level_nxt_s == LVL_ZERO);
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign level = level_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/avalon_st_sink_fifo.sv
// Avalon-ST sink buffer: handshake decode around avst_sync_fifo plus optional
// framing checker enabled by AVST_SINK_FRAME_CHECK_EN.
module avalon_st_sink_fifo
    import avst_pkg::*;
#(
    parameter int DATA_W = AVST_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    avalon_st_sink_fifo_if.slave       in_st,
    avalon_st_sink_fifo_if.master      out_st,
`ifdef AVST_SINK_FRAME_CHECK_EN
    output logic                       frame_err,
    output logic [PKT_CNT_W-1:0]       pkt_count,
`endif
    output logic [$clog2(DEPTH):0]     level
);

    localparam int WW = DATA_W + 2;

    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [WW-1:0] wr_word_s;
    logic [WW-1:0] rd_word_s;

    // Flags come straight from registers, so ready has no path from out_ready.
    assign in_st.ready  = ~full_s;
    assign out_st.valid = ~empty_s;
    assign push_s       = in_st.valid & ~full_s;
    assign pop_s        = out_st.ready & ~empty_s;

    assign wr_word_s  = {in_st.sop, in_st.eop, in_st.data};
    assign out_st.sop = rd_word_s[WW-1];
    assign out_st.eop = rd_word_s[WW-2];
    assign out_st.data = rd_word_s[DATA_W-1:0];

    avst_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wr_word_s),
        .rdata (rd_word_s),
        .level (level),
        .full  (full_s),
        .empty (empty_s)
    );

`ifdef AVST_SINK_FRAME_CHECK_EN
    localparam logic [PKT_CNT_W-1:0] CNT_ONE = PKT_CNT_W'(1);

    frame_state_e state_r;

    // Framing FSM on accepted beats; a sop inside a frame restarts the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            frame_err <= 1'b0;
            pkt_count <= '0;
        end else if (push_s) begin
            case (state_r)
                IDLE: begin
                    if (in_st.sop && in_st.eop) begin
                        pkt_count <= pkt_count + CNT_ONE;
                    end else if (in_st.sop) begin
                        state_r <= IN_PKT;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                IN_PKT: begin
                    if (in_st.sop) begin
                        frame_err <= 1'b1;
                    end else begin
                        frame_err <= frame_err;
                    end
                    if (in_st.eop) begin
                        state_r   <= IDLE;
                        pkt_count <= pkt_count + CNT_ONE;
                    end else begin
                        state_r <= IN_PKT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_st_sink_fifo.sv
// Scoreboard bench for avalon_st_sink_fifo: directed scenarios plus random traffic.
module tb_avalon_st_sink_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] level;
`ifdef AVST_SINK_FRAME_CHECK_EN
    logic        frame_err;
    logic [15:0] pkt_count;
`endif

    int tests = 0;
    int fails = 0;

    avalon_st_sink_fifo_if #(.DATA_W(DW)) in_if ();
    avalon_st_sink_fifo_if #(.DATA_W(DW)) out_if ();

    avalon_st_sink_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_st     (in_if),
        .out_st    (out_if),
`ifdef AVST_SINK_FRAME_CHECK_EN
        .frame_err (frame_err),
        .pkt_count (pkt_count),
`endif
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted beats in a queue, framing as plain flags.
    logic [17:0] q[$];
    bit          armed = 1'b0;
    bit          m_in_pkt;
    bit          m_err;
    int          m_cnt;

    always @(negedge clk) begin
        bit will_pop;
        bit will_push;
        if (armed) begin
            chk("level", 64'(level), 64'(q.size()));
            chk("in_ready", 64'(in_if.ready), 64'(q.size() != DEPTH));
            chk("out_valid", 64'(out_if.valid), 64'(q.size() != 0));
            if (q.size() != 0)
                chk("out_word", 64'({out_if.sop, out_if.eop, out_if.data}), 64'(q[0]));
`ifdef AVST_SINK_FRAME_CHECK_EN
            chk("frame_err", 64'(frame_err), 64'(m_err));
            chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
`endif
        end
        if (reset) begin
            q.delete();
            m_in_pkt = 1'b0;
            m_err    = 1'b0;
            m_cnt    = 0;
            armed    = 1'b1;
        end else if (armed) begin
            will_pop  = (q.size() != 0) && out_if.ready;
            will_push = in_if.valid && (q.size() != DEPTH);
            if (will_push) begin
                if (!m_in_pkt) begin
                    if (in_if.sop && in_if.eop) m_cnt = (m_cnt + 1) % 65536;
                    else if (in_if.sop) m_in_pkt = 1'b1;
                    else m_err = 1'b1;
                end else begin
                    if (in_if.sop) m_err = 1'b1;
                    if (in_if.eop) begin
                        m_in_pkt = 1'b0;
                        m_cnt = (m_cnt + 1) % 65536;
                    end
                end
            end
            if (will_pop) void'(q.pop_front());
            if (will_push) q.push_back({in_if.sop, in_if.eop, in_if.data});
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic s,
                        input logic e, input logic ordy);
        in_if.valid  = v;
        in_if.data   = d;
        in_if.sop    = s;
        in_if.eop    = e;
        out_if.ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        in_if.valid = 1'b0; in_if.data = 16'h0000; in_if.sop = 1'b0; in_if.eop = 1'b0;
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_in_ready", 64'(in_if.ready), 64'd1);
        chk("rst_out_valid", 64'(out_if.valid), 64'd0);
        reset = 1'b0;

        // Fill with out_ready low, then offer a fifth beat.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0, 1'b0);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_in_ready", 64'(in_if.ready), 64'd0);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("fifth_rejected_level", 64'(level), 64'd4);
        chk("fifth_rejected_head", 64'(out_if.data), 64'h0A00);
        drain();

        // Single push into empty buffer.
        step(1'b1, 16'hF800, 1'b1, 1'b1, 1'b1);
        chk("single_valid", 64'(out_if.valid), 64'd1);
        chk("single_data", 64'(out_if.data), 64'hF800);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("single_level0", 64'(level), 64'd0);

        // Streaming across pointer wrap.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
            chk("stream_level", 64'(level), 64'd1);
        end
        drain();

        // Full buffer with pop and in_valid in the same cycle.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h0B00 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1);
        chk("fullpop_in_ready", 64'(in_if.ready), 64'd1);
        chk("fullpop_level", 64'(level), 64'd3);
        drain();

`ifdef AVST_SINK_FRAME_CHECK_EN
        reset = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0003, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h0004, 1'b0, 1'b0, 1'b1);
        chk("frame_pkt_count", 64'(pkt_count), 64'd1);
        chk("frame_err_set", 64'(frame_err), 64'd1);
        reset = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        chk("frame_cnt_rst", 64'(pkt_count), 64'd0);
        chk("frame_err_rst", 64'(frame_err), 64'd0);
`endif

        // Reset mid-frame with three beats buffered; a beat offered during reset is dropped.
        step(1'b1, 16'h0C01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0C02, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0C03, 1'b0, 1'b0, 1'b0);
        chk("midrst_pre_level", 64'(level), 64'd3);
        reset = 1'b1;
        step(1'b1, 16'h0C04, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        chk("midrst_out_valid", 64'(out_if.valid), 64'd0);
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_in_ready", 64'(in_if.ready), 64'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
        end
        reset = 1'b0;
        drain();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
